// File: rtl/logic_unit_seq_if.sv
// logic_unit_seq_if: operand/result handshake bundle for logic_unit_seq.
//   Operand side : in_valid, in_ready, a, b, op, acc_mode, in_last
//   Result side  : out_valid, out_ready, y, zero, count, cnt_sat
//   master = operand source / result consumer, slave = logic_unit_seq.
interface logic_unit_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic [CNT_W-1:0] count;
  logic             cnt_sat;

  modport master (
    output in_valid, a, b, op, acc_mode, in_last, out_ready,
    input  in_ready, out_valid, y, zero, count, cnt_sat
  );

  modport slave (
    input  in_valid, a, b, op, acc_mode, in_last, out_ready,
    output in_ready, out_valid, y, zero, count, cnt_sat
  );
endinterface

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: handshaked bitwise logic unit with a burst-accumulate mode.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : logic_unit_seq_if.slave
//          operand beat in (in_valid/in_ready, a, b, op, acc_mode, in_last)
//          registered result out (out_valid/out_ready, y, zero, count, cnt_sat)
// Ops: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS.
// Accumulate folds acc = g(a, acc) with the op latched on the first beat.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  logic_unit_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bitwise operation table, g(x, z).
  function automatic logic [WIDTH-1:0] f_op(
    input logic [2:0]       i_op,
    input logic [WIDTH-1:0] i_x,
    input logic [WIDTH-1:0] i_z
  );
    logic [WIDTH-1:0] r;
    r = i_x;
    case (i_op)
      3'd0:    r = i_x & i_z;
      3'd1:    r = i_x | i_z;
      3'd2:    r = ~i_x;
      3'd3:    r = i_x ^ i_z;
      3'd4:    r = ~(i_x & i_z);
      3'd5:    r = ~(i_x | i_z);
      3'd6:    r = ~(i_x ^ i_z);
      default: r = i_x;
    endcase
    return r;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_acc;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_count;
  logic             r_cnt_sat;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_zero;

  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_acc_next = f_op(r_op, bus.a, r_acc);
  assign w_zero     = (r_y == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (bus.acc_mode && !bus.in_last) ? S_ACCUM : S_HOLD;
        end
      end
      S_ACCUM: begin
        if (w_accept && bus.in_last) begin
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes: no out_ready -> in_ready path.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready  = 1'b1;
      S_ACCUM: w_in_ready  = 1'b1;
      S_HOLD:  w_out_valid = 1'b1;
      default: w_in_ready  = 1'b0;
    endcase
  end

  // Datapath: result, accumulator, latched op and saturating beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_op      <= '0;
      r_y       <= '0;
      r_count   <= '0;
      r_cnt_sat <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_ACCUM) begin
        // Continuing burst: op/acc_mode/b are ignored, latched op applies.
        r_acc <= w_acc_next;
        if (r_count == CNT_MAX) begin
          r_cnt_sat <= 1'b1;
        end else begin
          r_count <= r_count + CNT_ONE;
        end
        if (bus.in_last) begin
          r_y <= w_acc_next;
        end
      end else begin
        // First beat of a burst or a single per-beat operation.
        r_count   <= CNT_ONE;
        r_cnt_sat <= 1'b0;
        if (!bus.acc_mode) begin
          r_y <= f_op(bus.op, bus.a, bus.b);
        end else if (bus.in_last) begin
          r_y <= bus.a;
        end else begin
          r_acc <= bus.a;
          r_op  <= bus.op;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.y         = r_y;
  assign bus.zero      = w_zero;
  assign bus.count     = r_count;
  assign bus.cnt_sat   = r_cnt_sat;

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: drives two logic_unit_seq instances (CNT_W=4 and CNT_W=2)
// with identical stimulus and checks both against a burst-level queue model.
module tb_logic_unit_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid, acc_mode, in_last, out_ready;
  logic [7:0] a, b;
  logic [2:0] op;

  int n_tests = 0;
  int n_fail  = 0;

  logic_unit_seq_if #(.WIDTH(8), .CNT_W(4)) ifa ();
  logic_unit_seq_if #(.WIDTH(8), .CNT_W(2)) ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.a        = a;         assign ifb.a        = a;
  assign ifa.b        = b;         assign ifb.b        = b;
  assign ifa.op       = op;        assign ifb.op       = op;
  assign ifa.acc_mode = acc_mode;  assign ifb.acc_mode = acc_mode;
  assign ifa.in_last  = in_last;   assign ifb.in_last  = in_last;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

  logic_unit_seq #(.WIDTH(8), .CNT_W(4)) u_dut     (.clk(clk), .rst(rst), .bus(ifa));
  logic_unit_seq #(.WIDTH(8), .CNT_W(2)) u_dut_sat (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] g(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~x;
      3'd3: return x ^ z;
      3'd4: return ~(x & z);
      3'd5: return ~(x | z);
      3'd6: return ~(x ^ z);
      default: return x;
    endcase
  endfunction

  bit         m_hold, m_burst;
  logic [7:0] m_y;
  int         m_n;
  logic [2:0] m_op;
  logic [7:0] q[$];

  initial begin
    m_hold = 0; m_burst = 0; m_y = '0; m_n = 0; m_op = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_hold = 0; m_burst = 0; m_y = '0; m_n = 0; q.delete();
      end else if (m_hold) begin
        if (out_ready) m_hold = 0;
      end else if (in_valid) begin
        if (!m_burst && !acc_mode) begin
          m_y = g(op, a, b); m_n = 1; m_hold = 1;
        end else begin
          if (!m_burst) begin q.delete(); m_op = op; end
          q.push_back(a);
          if (in_last) begin
            logic [7:0] r;
            r = q[0];
            for (int i = 1; i < q.size(); i++) r = g(m_op, q[i], r);
            m_y = r; m_n = q.size(); m_hold = 1; m_burst = 0;
          end else begin
            m_burst = 1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready",      32'(ifa.in_ready),  32'(!m_hold));
        chk("out_valid",     32'(ifa.out_valid), 32'(m_hold));
        chk("sat_in_ready",  32'(ifb.in_ready),  32'(!m_hold));
        chk("sat_out_valid", 32'(ifb.out_valid), 32'(m_hold));
        if (m_hold) begin
          chk("y",       32'(ifa.y),       32'(m_y));
          chk("zero",    32'(ifa.zero),    32'(m_y == 8'h00));
          chk("count",   32'(ifa.count),   32'((m_n > 15) ? 15 : m_n));
          chk("cnt_sat", 32'(ifa.cnt_sat), 32'(m_n > 15));
          chk("y2",      32'(ifb.y),       32'(m_y));
          chk("count2",  32'(ifb.count),   32'((m_n > 3) ? 3 : m_n));
          chk("cnt_sat2",32'(ifb.cnt_sat), 32'(m_n > 3));
        end
      end
    end
  end

  // ---------------- directed helpers (called at posedge+1) ----------------
  task automatic beat(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                      input logic tacc, input logic tlast);
    int k;
    in_valid = 1'b1; a = ta; b = tb; op = top; acc_mode = tacc; in_last = tlast;
    k = 0;
    while (!ifa.in_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!ifa.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL beat_accept_timeout: in_ready never rose at %0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic take();
    int k;
    k = 0;
    while (!ifa.out_valid && k < 20) begin @(posedge clk); #1; k++; end
    if (!ifa.out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL take_timeout: out_valid never rose at %0t", $time);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic res(input string nm, input logic [7:0] ey, input logic ez,
                     input int c4, input int c2, input logic s4, input logic s2);
    chk({nm, "_valid"}, 32'(ifa.out_valid), 32'(1));
    chk({nm, "_y"},     32'(ifa.y),         32'(ey));
    chk({nm, "_zero"},  32'(ifa.zero),      32'(ez));
    chk({nm, "_cnt"},   32'(ifa.count),     32'(c4));
    chk({nm, "_cnt2"},  32'(ifb.count),     32'(c2));
    chk({nm, "_sat"},   32'(ifa.cnt_sat),   32'(s4));
    chk({nm, "_sat2"},  32'(ifb.cnt_sat),   32'(s2));
  endtask

  task automatic reset_state(input string nm);
    chk({nm, "_out_valid"}, 32'(ifa.out_valid), 32'(0));
    chk({nm, "_in_ready"},  32'(ifa.in_ready),  32'(1));
    chk({nm, "_y"},         32'(ifa.y),         32'(0));
    chk({nm, "_zero"},      32'(ifa.zero),      32'(1));
    chk({nm, "_cnt"},       32'(ifa.count),     32'(0));
    chk({nm, "_cnt2"},      32'(ifb.count),     32'(0));
    chk({nm, "_sat2"},      32'(ifb.cnt_sat),   32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lastp;
    in_valid = 0; a = '0; b = '0; op = '0; acc_mode = 0; in_last = 0; out_ready = 0;
    #12 rst = 1'b0;
    #1 reset_state("por");
    @(posedge clk); #1;

    beat(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0); res("and1", 8'h30, 1'b0, 1, 1, 0, 0); take();
    beat(8'h0F, 8'hF0, 3'd0, 1'b0, 1'b0); res("and2", 8'h00, 1'b1, 1, 1, 0, 0); take();
    beat(8'hA5, 8'h00, 3'd2, 1'b0, 1'b0); res("not",  8'h5A, 1'b0, 1, 1, 0, 0); take();
    beat(8'hA5, 8'hA5, 3'd6, 1'b0, 1'b0); res("xnor", 8'hFF, 1'b0, 1, 1, 0, 0); take();

    beat(8'h01, 8'hFF, 3'd3, 1'b1, 1'b0);
    beat(8'h02, 8'hFF, 3'd0, 1'b1, 1'b0);
    beat(8'h04, 8'hFF, 3'd0, 1'b1, 1'b1);
    res("accxor", 8'h07, 1'b0, 3, 3, 0, 0);
    chk("model_accxor", 32'(m_y), 32'(8'h07));
    take();

    // Backpressure: offered beats must be refused while the result is held.
    beat(8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0);
    in_valid = 1'b1; a = 8'h77; b = 8'h00; op = 3'd7; acc_mode = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_y", 32'(ifa.y), 32'(8'h0F));
      chk("bp_in_ready", 32'(ifa.in_ready), 32'(0));
      chk("bp_cnt", 32'(ifa.count), 32'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(ifa.out_valid), 32'(0));
    chk("bp_release_ready", 32'(ifa.in_ready),  32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    res("bp_next", 8'h77, 1'b0, 1, 1, 0, 0);
    take();

    // Asynchronous reset in the middle of a burst.
    beat(8'hAA, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h55, 8'h00, 3'd1, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1 reset_state("midrst");
    #1 rst = 1'b0;
    #1 chk("midrst_in_ready", 32'(ifa.in_ready), 32'(1));
    @(posedge clk); #1;
    beat(8'h11, 8'h22, 3'd1, 1'b0, 1'b0); res("or_after_rst", 8'h33, 1'b0, 1, 1, 0, 0); take();

    // Saturation on the CNT_W=2 instance.
    beat(8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h02, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h04, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h08, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h10, 8'h00, 3'd1, 1'b1, 1'b1);
    res("sat", 8'h1F, 1'b0, 5, 3, 0, 1);
    chk("model_sat", 32'(m_y), 32'(8'h1F));
    take();
    beat(8'h3C, 8'h0F, 3'd0, 1'b0, 1'b0); res("sat_clear", 8'h0C, 1'b0, 1, 1, 0, 0);
    take();

    // out_ready while idle has no effect.
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_out_ready", 32'(ifa.out_valid), 32'(0));
    end
    out_ready = 1'b0;

    // Random traffic; second half uses long bursts to reach saturation.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      lastp = (cyc < 2000) ? 4 : 24;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = 3'($urandom);
      acc_mode  = 1'($urandom);
      in_last   = ($urandom_range(0, lastp - 1) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
